// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine command controller:
// command/error encodings, controller states and item prices.
package vm_pkg;

    typedef enum logic [1:0] {
        CMD_SITEM  = 2'b00,
        CMD_SMONEY = 2'b01,
        CMD_CLEAR  = 2'b10,
        CMD_START  = 2'b11
    } cmd_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'b00,
        ERR_FUNDS      = 2'b01,
        ERR_NO_SEL     = 2'b10,
        ERR_CANCEL_SEL = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_SHOP,
        ST_VEND_KEEP,
        ST_VEND_ALL,
        ST_SETTLE
    } state_t;

    // Item prices in $0.125 units.
    localparam logic [15:0] PRICE_A = 16'd14;
    localparam logic [15:0] PRICE_B = 16'd12;
    localparam logic [15:0] PRICE_C = 16'd10;
    localparam logic [15:0] PRICE_D = 16'd8;

    function automatic cmd_t state_cmd(input state_t s);
        case (s)
            ST_INIT:      return CMD_CLEAR;
            ST_VEND_KEEP: return CMD_SITEM;
            ST_VEND_ALL:  return CMD_SMONEY;
            default:      return CMD_START;
        endcase
    endfunction

endpackage

// File: rtl/vm_timer.sv
// Loadable/clearable 16-bit down-counter; tc is high while the count is zero.
module vm_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    output logic        tc
);

    logic [15:0] count;

    always_ff @(negedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != 16'd0)) begin
            count <= count - 16'd1;
        end
    end

    assign tc = (count == 16'd0);

endmodule

// File: rtl/vm_ctrl.sv
// Vending-machine command controller: arbitrates user requests in SHOP,
// issues single-cycle vend/refund commands and enforces the idle refund.
module vm_ctrl
    import vm_pkg::*;
#(
    parameter int CLEAR_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int TIMEOUT       = 1000
) (
    input  logic               in_clka,
    input  logic               in_restart,
    input  logic               in_buy,
    input  logic               in_buy_more,
    input  logic               in_cancel,
    input  logic               in_coin_any,
    input  logic               in_sel_any,
    input  logic signed [15:0] in_change,
    input  logic [3:0]         in_csel,
    output logic [1:0]         out_cmd,
    output logic               out_busy,
    output logic               out_done,
    output logic               out_err,
    output logic [1:0]         out_err_code
);

    localparam logic [15:0] CLEAR_LOAD  = 16'(CLEAR_CYCLES - 1);
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] IDLE_LOAD   = 16'(TIMEOUT - 1);

    state_t      state, nxt;
    logic        init_armed;
    logic        tmr_clr, tmr_load, tmr_en, tmr_tc;
    logic [15:0] tmr_val;
    logic        err_set;
    err_t        err_code;
    logic        no_sel, activity;

    assign no_sel   = (in_csel == 4'd0);
    assign activity = in_coin_any | in_sel_any | in_buy | in_buy_more | in_cancel;

    vm_timer u_timer (
        .clk      (in_clka),
        .rst      (in_restart),
        .clr      (tmr_clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    // The command bus has no handshake: dp acts on out_cmd at the edge after it
    // is driven, so SITEM/SMONEY are held for exactly one cycle and START is idle.
    always_comb begin
        nxt      = state;
        tmr_clr  = 1'b0;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        tmr_val  = '0;
        err_set  = 1'b0;
        err_code = ERR_NONE;
        unique case (state)
            ST_INIT: begin
                // First cycle after reset arms the clear count; the timer sits at zero until then.
                if (!init_armed) begin
                    tmr_load = 1'b1;
                    tmr_val  = CLEAR_LOAD;
                end else if (tmr_tc) begin
                    nxt      = ST_SHOP;
                    tmr_load = 1'b1;
                    tmr_val  = IDLE_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_SHOP: begin
                if (in_cancel) begin
                    if (no_sel) nxt = ST_VEND_ALL;
                    else begin
                        err_set  = 1'b1;
                        err_code = ERR_CANCEL_SEL;
                    end
                end else if (in_buy) begin
                    if (no_sel) begin
                        err_set  = 1'b1;
                        err_code = ERR_NO_SEL;
                    end else if (in_change < 16'sd0) begin
                        err_set  = 1'b1;
                        err_code = ERR_FUNDS;
                    end else nxt = ST_VEND_ALL;
                end else if (in_buy_more) begin
                    if (no_sel) begin
                        err_set  = 1'b1;
                        err_code = ERR_NO_SEL;
                    end else if (in_change <= 16'sd0) begin
                        err_set  = 1'b1;
                        err_code = ERR_FUNDS;
                    end else nxt = ST_VEND_KEEP;
                end else if (tmr_tc && no_sel && (in_change > 16'sd0)) begin
                    nxt = ST_VEND_ALL;
                end
                if (nxt != ST_SHOP) begin
                    tmr_clr = 1'b1;
                end else if (activity || tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = IDLE_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_VEND_KEEP, ST_VEND_ALL: begin
                nxt      = ST_SETTLE;
                tmr_load = 1'b1;
                tmr_val  = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (tmr_tc) begin
                    nxt      = ST_SHOP;
                    tmr_load = 1'b1;
                    tmr_val  = IDLE_LOAD;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            default: nxt = ST_INIT;
        endcase
    end

    always_ff @(negedge in_clka) begin
        if (in_restart) begin
            state        <= ST_INIT;
            init_armed   <= 1'b0;
            out_cmd      <= CMD_CLEAR;
            out_busy     <= 1'b1;
            out_done     <= 1'b0;
            out_err      <= 1'b0;
            out_err_code <= ERR_NONE;
        end else begin
            state      <= nxt;
            init_armed <= (nxt == ST_INIT);
            out_cmd    <= state_cmd(nxt);
            out_busy   <= (nxt != ST_SHOP);
            out_done   <= (nxt == ST_VEND_KEEP) || (nxt == ST_VEND_ALL);
            out_err    <= err_set;
            if (err_set) out_err_code <= err_code;
        end
    end

endmodule

// File: doc/vm_ctrl.md
# vm_ctrl

Command controller for the vending machine. It is the initiator of the 2-bit command interface consumed by the datapath `dp`. It samples user buttons plus datapath status (signed change, confirmed selections), runs the transaction state machine and drives `out_cmd`. It also enforces an inactivity refund timeout and reports rejected requests.

## Interface
- `CLEAR_CYCLES`, default 2: cycles `CLEAR_CMD` is held after reset.
- `SETTLE_CYCLES`, default 4: lockout cycles after each vend or refund.
- `TIMEOUT`, default 1000: inactivity cycles in SHOP before auto-refund (≥2, ≤65535).
- `in_clka`  input  1  clock; all logic on negedge, matching `dp`.
- `in_restart`  input  1  reset, synchronous, active-high.
- `in_buy`  input  1  pulse: vend selection and return all change.
- `in_buy_more`  input  1  pulse: vend selection and keep the remaining credit.
- `in_cancel`  input  1  pulse: refund credit with no vend.
- `in_coin_any`  input  1  OR of the four coin-inserted strobes.
- `in_sel_any`  input  1  OR of the four selection strobes.
- `in_change`  input  16 signed  `dp` change: credit minus selected price, in $0.125 units.
- `in_csel`  input  4  `dp` confirmed selections {d,c,b,a}.
- `out_cmd`  output  2  command to `dp`: SITEM=00, SMONEY=01, CLEAR=10, START=11.
- `out_busy`  output  1  high in every state except SHOP.
- `out_done`  output  1  one-cycle pulse on the cycle a vend or refund command is driven.
- `out_err`  output  1  one-cycle pulse on a rejected request.
- `out_err_code`  output  2  01 insufficient funds, 10 no selection, 11 cancel with selection pending. Holds its value until the next error.

## Operation
- States: INIT, SHOP, VEND_KEEP, VEND_ALL, SETTLE.
- INIT:
  - `out_cmd`=CLEAR.
  - Stays for CLEAR_CYCLES cycles counted after `in_restart` falls, then goes to SHOP.
- SHOP: `out_cmd`=START. Requests are evaluated in fixed priority: cancel > buy > buy_more > timeout.
  - cancel:
    - `in_csel`==0 → VEND_ALL. SMONEY with no selection is a pure refund.
    - Otherwise err 11, stay in SHOP.
  - buy:
    - `in_csel`==0 → err 10.
    - `in_change`<0 → err 01.
    - Otherwise → VEND_ALL.
  - buy_more:
    - `in_csel`==0 → err 10.
    - `in_change`≤0 → err 01. `dp` requires strictly positive credit after the purchase.
    - Otherwise → VEND_KEEP.
  - A lower-priority request in the same cycle as an accepted or rejected higher one is dropped.
- VEND_KEEP: `out_cmd`=SITEM for exactly 1 cycle, `out_done`=1, then SETTLE.
- VEND_ALL: `out_cmd`=SMONEY for exactly 1 cycle, `out_done`=1, then SETTLE.
- SETTLE:
  - `out_cmd`=START for SETTLE_CYCLES cycles, then SHOP.
  - All button inputs are ignored, not queued.
- Inactivity timer:
  - 16-bit counter, runs only in SHOP.
  - Cleared on any of `in_coin_any`, `in_sel_any`, `in_buy`, `in_buy_more`, `in_cancel`. Also cleared on leaving SHOP.
  - At count TIMEOUT-1:
    - If `in_csel`==0 and `in_change`>0 → VEND_ALL (auto-refund).
    - Otherwise the counter clears and no action is taken.
  - Timeout never vends items.
- Comparisons on `in_change` are signed, two's complement, full 16 bits.

## Timing
- Reset values: state INIT, `out_cmd`=CLEAR, `out_busy`=1, `out_done`=0, `out_err`=0, `out_err_code`=00, timer 0.
- All outputs are registered. A request sampled on edge N changes `out_cmd` after edge N. `dp` acts on edge N+1.
- Request-to-command latency is 1 cycle. Command-to-next-request minimum is 1+SETTLE_CYCLES cycles.
- `in_restart` asserted in any state: at the next edge go to INIT, `out_cmd`=CLEAR. Any in-flight SITEM/SMONEY is abandoned.
- Reset held for multiple cycles keeps `out_cmd`=CLEAR throughout. The CLEAR_CYCLES count starts on the first edge with reset low.
- An error pulse and a state change never occur in the same cycle.

## Structure
- Shared package `vm_pkg`: command encodings, error codes, state enum, item price constants (A=14, B=12, C=10, D=8).
- Sub-module `vm_timer`: loadable/clearable 16-bit down-counter with terminal-count flag. Used for the INIT, SETTLE and inactivity counts.
- FSM and request arbitration live in `vm_ctrl`.

## Test plan
- Reset held 3 cycles, then released → `out_cmd`=CLEAR for 3+2 cycles, then START; `out_busy` falls.
- `in_csel`=0001, `in_change`=6, `in_buy` pulse → next cycle SMONEY and `out_done`=1. Then 4 cycles of START with `out_busy`=1, then SHOP.
- `in_csel`=0010, `in_change`=0: `in_buy_more` → err 01; `in_buy` → SMONEY.
- `in_csel`=0100 with `in_cancel` and `in_buy` in the same cycle → err 11 only, no command issued.
- Idle in SHOP with `in_csel`=0, `in_change`=40, TIMEOUT=10 → SMONEY at cycle 10. Repeat with a coin strobe at cycle 5 → SMONEY at cycle 15.
- `in_restart` asserted during VEND_ALL → CLEAR on the next cycle and no SETTLE phase. A buy pulse during SETTLE is ignored.
